// File: rtl/int_ctrl_pkg.sv
// Shared register offsets and helpers for the platform interrupt controller.
package int_ctrl_pkg;

  localparam int ID_W = 5;

  localparam logic [7:0] INT_PENDING   = 8'h00;
  localparam logic [7:0] INT_ENABLE    = 8'h04;
  localparam logic [7:0] INT_THRESHOLD = 8'h08;
  localparam logic [7:0] INT_CLAIM     = 8'h0C;
  localparam logic [7:0] INT_PRIO_BASE = 8'h40;

  localparam logic [ID_W-1:0] INT_ID_NONE = '0;

  function automatic logic [7:0] prio_addr(input int id);
    return INT_PRIO_BASE + 8'(4 * id);
  endfunction

endpackage

// File: rtl/int_ctrl_arbiter.sv
// Combinational winner select: highest priority above threshold, ties to lowest ID.
module int_ctrl_arbiter
  import int_ctrl_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic [NSRC-1:0]        cand_i,
  input  logic [NSRC*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]      threshold_i,
  output logic [ID_W-1:0]        best_id_o,
  output logic                   best_valid_o
);

  logic [PRIO_W-1:0] best_prio;
  logic [PRIO_W-1:0] p;

  always_comb begin
    best_id_o    = INT_ID_NONE;
    best_valid_o = 1'b0;
    best_prio    = '0;
    p            = '0;
    // Strict '>' keeps the earlier (lower) ID on equal priority.
    for (int i = 0; i < NSRC; i++) begin
      p = prio_i[i*PRIO_W +: PRIO_W];
      if (cand_i[i] && (p > threshold_i) && (!best_valid_o || (p > best_prio))) begin
        best_valid_o = 1'b1;
        best_prio    = p;
        best_id_o    = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller top: per-source gateway, register file, bus decode,
// claim/complete handling and the registered external_int output.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src_irq,
  input  logic [7:0]      bus_addr,
  input  logic [31:0]     bus_wdata,
  input  logic            bus_write,
  input  logic            bus_read,
  output logic [31:0]     bus_rdata,
  output logic            external_int
);

  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   inflight_q, inflight_d;
  logic [NSRC-1:0]   enable_q, enable_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [PRIO_W-1:0] prio_d [NSRC];
  logic [31:0]       rdata_q, rdata_d;
  logic              ext_int_q;

  logic [NSRC*PRIO_W-1:0] prio_flat;
  logic [ID_W-1:0]        best_id;
  logic                   best_valid;
  logic [7:0]             addr_w;
  logic [31:0]            rd_val;
  logic                   claim_rd;
  logic [NSRC-1:0]        claim_mask, complete_mask, gw_set;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^bus_addr[1:0];

  always_comb begin
    prio_flat = '0;
    for (int i = 0; i < NSRC; i++) prio_flat[i*PRIO_W +: PRIO_W] = prio_q[i];
  end

  int_ctrl_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W)) u_arb (
    .cand_i       (pending_q & enable_q),
    .prio_i       (prio_flat),
    .threshold_i  (threshold_q),
    .best_id_o    (best_id),
    .best_valid_o (best_valid)
  );

  always_comb begin
    addr_w        = {bus_addr[7:2], 2'b00};
    enable_d      = enable_q;
    threshold_d   = threshold_q;
    prio_d        = prio_q;
    rd_val        = '0;
    claim_mask    = '0;
    complete_mask = '0;
    claim_rd      = bus_read && (addr_w == INT_CLAIM) && best_valid;

    case (addr_w)
      INT_PENDING:   rd_val[NSRC-1:0]   = pending_q;
      INT_ENABLE:    rd_val[NSRC-1:0]   = enable_q;
      INT_THRESHOLD: rd_val[PRIO_W-1:0] = threshold_q;
      INT_CLAIM:     rd_val[ID_W-1:0]   = best_id;
      default:       ;
    endcase

    for (int i = 0; i < NSRC; i++) begin
      if (addr_w == prio_addr(i + 1)) rd_val[PRIO_W-1:0] = prio_q[i];
      claim_mask[i]    = claim_rd && (best_id == ID_W'(i + 1));
      // Full-width compare so IDs above NSRC never alias onto a real source.
      complete_mask[i] = bus_write && (addr_w == INT_CLAIM) && (bus_wdata == 32'(i + 1));
    end

    if (bus_write) begin
      if (addr_w == INT_ENABLE)    enable_d    = bus_wdata[NSRC-1:0];
      if (addr_w == INT_THRESHOLD) threshold_d = bus_wdata[PRIO_W-1:0];
      for (int i = 0; i < NSRC; i++) begin
        if (addr_w == prio_addr(i + 1)) prio_d[i] = bus_wdata[PRIO_W-1:0];
      end
    end

    gw_set     = src_irq & ~pending_q & ~inflight_q;
    pending_d  = (pending_q & ~claim_mask) | gw_set;
    inflight_d = (inflight_q & ~complete_mask) | claim_mask;
    rdata_d    = bus_read ? rd_val : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= '0;
      inflight_q  <= '0;
      enable_q    <= '0;
      threshold_q <= '0;
      prio_q      <= '{default: '0};
      rdata_q     <= '0;
      ext_int_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      inflight_q  <= inflight_d;
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      prio_q      <= prio_d;
      rdata_q     <= rdata_d;
      ext_int_q   <= best_valid;
    end
  end

  assign bus_rdata    = rdata_q;
  assign external_int = ext_int_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: register vector table plus claim/complete sequences.
module tb_int_ctrl;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] src_irq = '0;
  logic [7:0]      bus_addr = '0;
  logic [31:0]     bus_wdata = '0;
  logic            bus_write = 1'b0;
  logic            bus_read = 1'b0;
  logic [31:0]     bus_rdata;
  logic            external_int;

  int_ctrl #(.NSRC(NSRC), .PRIO_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_irq      (src_irq),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_write    (bus_write),
    .bus_read     (bus_read),
    .bus_rdata    (bus_rdata),
    .external_int (external_int)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];
  logic rd_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read data is registered: compare one edge after the strobe, on the falling edge.
  always @(posedge clk) rd_q <= bus_read;
  always @(negedge clk) begin
    if (rd_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got read data 0x%08h expected no read", bus_rdata);
      end else begin
        mon_e = sb.pop_front();
        chk(mon_e.name, bus_rdata, mon_e.exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NSRC-1:0] s);
    bus_read  = 1'b0;
    bus_write = 1'b0;
    src_irq   = s;
    rst_n     = 1'b0;
    cyc(2);
    rst_n     = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_write = 1'b1;
    cyc(1);
    bus_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    bus_addr = a;
    bus_read = 1'b1;
    cyc(1);
    bus_read = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp,
                      input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    bus_addr  = a;
    bus_wdata = d;
    bus_read  = 1'b1;
    bus_write = 1'b1;
    cyc(1);
    bus_read  = 1'b0;
    bus_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h04, 32'hFFFF_FFFF, 32'h0000_00FF, "enable_width"};
    vecs[1] = '{8'h08, 32'hFFFF_FFFF, 32'h0000_0007, "threshold_width"};
    vecs[2] = '{8'h44, 32'h0000_000A, 32'h0000_0002, "prio1_width"};
    vecs[3] = '{8'h60, 32'h0000_0005, 32'h0000_0005, "prio8"};
    vecs[4] = '{8'h40, 32'h0000_0007, 32'h0000_0000, "prio_id0_unmapped"};
    vecs[5] = '{8'h64, 32'h0000_0007, 32'h0000_0000, "prio_id9_unmapped"};
    vecs[6] = '{8'h10, 32'h0000_00FF, 32'h0000_0000, "unmapped_0x10"};
    vecs[7] = '{8'h00, 32'h0000_00FF, 32'h0000_0000, "pending_read_only"};
    vecs[8] = '{8'h4E, 32'h0000_0003, 32'h0000_0003, "prio3_low_bits_ignored"};

    // Reset with every line high: registers clear, gateway captures lines afterwards.
    do_reset('1);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_ext_int", {31'h0, external_int}, 32'h0);
    rd(8'h04, 32'h0, "rst_enable");
    rd(8'h08, 32'h0, "rst_threshold");
    rd(8'h44, 32'h0, "rst_prio1");
    rd(8'h0C, 32'h0, "rst_claim_none");
    rd(8'h00, 32'hFF, "rst_pending_captured");
    cyc(2);
    chk("rst_ext_int_disabled", {31'h0, external_int}, 32'h0);
    chk("rdata_hold", bus_rdata, 32'hFF);
    src_irq = '0;

    do_reset('0);
    for (int k = 0; k < 9; k++) begin
      wr(vecs[k].addr, vecs[k].wdata);
      rd(vecs[k].addr, vecs[k].exp, vecs[k].name);
    end

    // Single source latency and claim.
    do_reset('0);
    wr(8'h4C, 32'd2);
    wr(8'h04, 32'h04);
    wr(8'h08, 32'd0);
    src_irq[2] = 1'b1;
    cyc(1);
    chk("single_ext_n1", {31'h0, external_int}, 32'h0);
    cyc(1);
    chk("single_ext_n2", {31'h0, external_int}, 32'h1);
    src_irq = '0;
    rd(8'h0C, 32'd3, "single_claim");
    cyc(1);
    chk("single_ext_after_claim", {31'h0, external_int}, 32'h0);
    rd(8'h00, 32'h0, "single_pending_cleared");
    wr(8'h0C, 32'd3);

    // Priority ordering with a tie.
    do_reset('0);
    wr(8'h48, 32'd5);
    wr(8'h54, 32'd5);
    wr(8'h5C, 32'd1);
    wr(8'h04, 32'h52);
    src_irq = 8'h52;
    cyc(1);
    src_irq = '0;
    cyc(2);
    chk("prio_ext_on", {31'h0, external_int}, 32'h1);
    rd(8'h0C, 32'd2, "prio_claim_2");
    wr(8'h0C, 32'd2);
    rd(8'h0C, 32'd5, "prio_claim_5");
    wr(8'h0C, 32'd5);
    rd(8'h0C, 32'd7, "prio_claim_7");
    wr(8'h0C, 32'd7);
    cyc(2);
    chk("prio_ext_off", {31'h0, external_int}, 32'h0);

    // Threshold blocks equal priority; lowering it raises the interrupt two cycles later.
    do_reset('0);
    wr(8'h44, 32'd3);
    wr(8'h04, 32'h01);
    wr(8'h08, 32'd3);
    src_irq[0] = 1'b1;
    cyc(3);
    chk("thresh_ext_blocked", {31'h0, external_int}, 32'h0);
    rd(8'h0C, 32'd0, "thresh_claim_none");
    wr(8'h08, 32'd2);
    chk("thresh_ext_lag", {31'h0, external_int}, 32'h0);
    cyc(1);
    chk("thresh_ext_on", {31'h0, external_int}, 32'h1);

    // Level re-trigger with src_irq[0] held high.
    rd(8'h0C, 32'd1, "level_claim_1");
    rd(8'h00, 32'h0, "level_pending_inflight");
    wr(8'h0C, 32'd9);
    wr(8'h0C, 32'd0);
    cyc(1);
    rd(8'h00, 32'h0, "level_bad_complete_ignored");
    chk("level_ext_off", {31'h0, external_int}, 32'h0);
    wr(8'h0C, 32'd1);
    cyc(1);
    rd(8'h00, 32'h1, "level_pending_retrigger");
    src_irq = '0;

    // Simultaneous read/write, gateway set during a claim.
    do_reset('0);
    wr(8'h50, 32'd2);
    wr(8'h58, 32'd7);
    wr(8'h48, 32'd7);
    wr(8'h04, 32'h08);
    src_irq[3] = 1'b1;
    cyc(1);
    src_irq = '0;
    cyc(1);
    src_irq[5] = 1'b1;
    rdwr(8'h04, 32'h2A, 32'h08, "simul_enable_prewrite");
    src_irq = '0;
    src_irq[1] = 1'b1;
    rd(8'h0C, 32'd6, "simul_claim_6");
    src_irq = '0;
    rd(8'h0C, 32'd2, "simul_claim_2");
    rd(8'h0C, 32'd4, "simul_claim_4");
    rd(8'h0C, 32'd0, "simul_claim_empty");
    rd(8'h00, 32'h0, "simul_pending_empty");
    rdwr(8'h0C, 32'd4, 32'd0, "simul_claim_with_complete");
    src_irq[3] = 1'b1;
    cyc(1);
    src_irq = '0;
    rd(8'h0C, 32'd4, "simul_reclaim_4");

    cyc(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
